cordic_sine_arbiter: RTL and testbench

- Shares one cordic_sine engine between NUM_REQ independent requesters.
- Grants requesters in round-robin order and accepts each angle over a valid/ready handshake.
- Issues a one-cycle start pulse to the engine, captures sine_out on the engine's valid pulse, and returns the result with the requester ID on one shared response channel with backpressure.
- Sits between the application-side angle sources and the single CORDIC datapath instance.

---
 rtl/cordic_sine_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_cordic_sine_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sine_arbiter.sv
// -----------------------------------------------------------------------------
// cordic_sine_arbiter
//   Shares one cordic_sine engine between NUM_REQ requesters. Requesters are
//   granted in round-robin order. Each granted angle is issued to the engine
//   with a one-cycle start pulse. The sine result is returned with the
//   requester index on a single response channel that supports backpressure.
//
// Optional feature: define CORDIC_ARB_TIMEOUT_EN to enable a WAIT-state
//   watchdog. If the engine does not answer within TIMEOUT cycles, the block
//   returns rsp_err=1 with rsp_data=0. Without the macro, rsp_err is tied to 0
//   and WAIT has no time limit.
//
// Parameters:
//   NUM_REQ  number of requesters (2..16)
//   ID_W     requester ID width (>= clog2(NUM_REQ))
//   TIMEOUT  watchdog limit in cycles (used only with CORDIC_ARB_TIMEOUT_EN)
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   req_valid  per-requester request valid
//   req_angle  flattened angles; slice i = [32i+31:32i]
//   req_ready  one-hot accept strobe (combinational, IDLE only)
//   rsp_valid  response valid
//   rsp_ready  response consumer ready
//   rsp_id     requester index of the response
//   rsp_data   sine result
//   rsp_err    watchdog error flag
//   eng_start  one-cycle engine start pulse
//   eng_angle  engine input angle
//   eng_sine   engine result
//   eng_valid  engine result valid (sampled only in WAIT)
//   busy       high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module cordic_sine_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*32-1:0]   req_angle,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_data,
  output logic                    rsp_err,
  output logic                    eng_start,
  output logic [31:0]             eng_angle,
  input  logic [31:0]             eng_sine,
  input  logic                    eng_valid,
  output logic                    busy
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  if (ID_W < IW || NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 1) begin : g_bad_cfg
    $error("cordic_sine_arbiter: illegal parameter combination");
  end

  logic [1:0]      r_state;
  logic [ID_W-1:0] r_rr_ptr;
  logic [31:0]     r_angle_q;
  logic [ID_W-1:0] r_id_q;
  logic [31:0]     r_rsp_data;
  logic            r_rsp_valid;

  logic [31:0]     w_angles [NUM_REQ];
  logic            w_found;
  logic [IW-1:0]   w_win_sel;
  logic [ID_W-1:0] w_winner;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_angles[i] = req_angle[i*32 +: 32];
    end
  end

  // Search starts one past the last winner and wraps, so the previous
  // winner has the lowest priority in the next round.
  always_comb begin
    int unsigned idx;
    w_found   = 1'b0;
    w_win_sel = '0;
    w_winner  = '0;
    idx       = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && req_valid[IW'(idx)]) begin
        w_found   = 1'b1;
        w_win_sel = IW'(idx);
        w_winner  = ID_W'(idx);
      end
    end
  end

  // The handshake is combinational. Gating it with rst ensures that no
  // requester sees an accept while the block is held in reset.
  always_comb begin
    req_ready = '0;
    if (!rst && r_state == S_IDLE && w_found) begin
      req_ready[w_win_sel] = 1'b1;
    end
  end

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_wd_cnt;
  logic          r_rsp_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= ID_W'(NUM_REQ - 1);
      r_angle_q   <= '0;
      r_id_q      <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_wd_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_angle_q <= w_angles[w_win_sel];
            r_id_q    <= w_winner;
            r_rr_ptr  <= w_winner;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wd_cnt <= '0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_valid) begin
            r_rsp_data  <= eng_sine;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_state     <= S_RESP;
          end else if (r_wd_cnt == CW'(TIMEOUT - 1)) begin
            // The last allowed WAIT cycle has passed without a result.
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
        end
        default: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign rsp_err = r_rsp_err;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= ID_W'(NUM_REQ - 1);
      r_angle_q   <= '0;
      r_id_q      <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_angle_q <= w_angles[w_win_sel];
            r_id_q    <= w_winner;
            r_rr_ptr  <= w_winner;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_valid) begin
            r_rsp_data  <= eng_sine;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        default: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign rsp_err = 1'b0;
`endif

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id_q;
  assign rsp_data  = r_rsp_data;
  assign eng_start = (r_state == S_ISSUE);
  assign eng_angle = r_angle_q;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_cordic_sine_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cordic_sine_arbiter
//   Directed testbench for cordic_sine_arbiter with a behavioural engine
//   model. The model asserts eng_valid 18 cycles after it sees eng_start.
//   Inputs are driven, and outputs sampled, 1 time unit after each falling
//   clock edge.
// -----------------------------------------------------------------------------
module tb_cordic_sine_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 64;
  localparam int ENG_LAT = 18;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_angle;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_data;
  logic                  rsp_err;
  logic                  eng_start;
  logic [31:0]           eng_angle;
  logic [31:0]           eng_sine;
  logic                  eng_valid;
  logic                  busy;

  logic [31:0] ang [NUM_REQ];
  logic        model_valid;
  logic        stray_valid;
  logic        eng_mute;

  int n_vec = 0;
  int n_err = 0;

  assign req_angle = {ang[3], ang[2], ang[1], ang[0]};
  assign eng_valid = model_valid | stray_valid;

  always #5 clk = ~clk;

  cordic_sine_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_angle(eng_angle),
    .eng_sine(eng_sine), .eng_valid(eng_valid), .busy(busy)
  );

  // Engine model: a one-cycle eng_valid pulse ENG_LAT cycles after start.
  initial begin
    int cd;
    cd = 0;
    model_valid = 1'b0;
    forever begin
      @(negedge clk);
      model_valid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0 && !eng_mute) model_valid = 1'b1;
      end
      if (eng_start) cd = ENG_LAT;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_rsp(input string tag, output int cycles);
    cycles = 0;
    while (!rsp_valid && cycles < 200) begin
      tick();
      cycles++;
    end
    check_val({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n_grant, n_rsp, n_start, lat, seen_at, n, bad;

    rst = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    stray_valid = 1'b0;
    eng_mute = 1'b0;
    eng_sine = 32'sh00008000;
    ang[0] = 32'h00001111;
    ang[1] = 32'h00002222;
    ang[2] = 32'h00003333;
    ang[3] = 32'h00004444;

    // Reset is held for 3 cycles while every requester is valid.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("rst_req_ready", 32'(req_ready), 32'd0);
      check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_val("rst_eng_start", 32'(eng_start), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
    end
    check_val("rst_rsp_id", 32'(rsp_id), 32'd0);
    check_val("rst_rsp_data", rsp_data, 32'd0);
    check_val("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_val("rst_eng_angle", eng_angle, 32'd0);

    // Round robin: all requesters remain valid until 8 grants have been made.
    rst = 1'b0;
    #1;
    check_val("first_grant", 32'(req_ready), 32'b0001);
    n_grant = 0; n_rsp = 0; n_start = 0;
    for (int cyc = 0; cyc < 400 && n_rsp < 8; cyc++) begin
      if (req_ready != '0) begin
        check_val("rr_grant", 32'(req_ready), 32'(1) << (n_grant % 4));
        n_grant++;
      end
      if (eng_start) begin
        n_start++;
        check_val("rr_eng_angle", eng_angle, ang[(n_grant - 1) % 4]);
      end
      if (rsp_valid) begin
        check_val("rr_rsp_id", 32'(rsp_id), 32'(n_rsp % 4));
        check_val("rr_rsp_data", rsp_data, 32'h00008000);
        check_val("rr_rsp_err", 32'(rsp_err), 32'd0);
        n_rsp++;
      end
      tick();
      if (n_grant == 8) req_valid = '0;
    end
    check_val("rr_grants", 32'(n_grant), 32'd8);
    check_val("rr_responses", 32'(n_rsp), 32'd8);
    check_val("rr_eng_starts", 32'(n_start), 32'd8);
    check_val("rr_idle_after", 32'(busy), 32'd0);

    // Single request from requester 2, with latency checks.
    rsp_ready = 1'b0;
    ang[2] = 32'sh0000C90F;
    req_valid = 4'b0100;
    #1;
    check_val("single_req_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    check_val("single_eng_start", 32'(eng_start), 32'd1);
    check_val("single_eng_angle", eng_angle, 32'h0000C90F);
    check_val("single_no_ready", 32'(req_ready), 32'd0);
    tick();
    check_val("single_start_pulse", 32'(eng_start), 32'd0);
    check_val("single_angle_held", eng_angle, 32'h0000C90F);
    lat = 1; seen_at = -1;
    while (!rsp_valid && lat < 100) begin
      if (eng_valid) seen_at = lat;
      tick();
      lat++;
    end
    check_val("single_rsp_lat", 32'(lat), 32'(seen_at + 1));
    check_val("single_rsp_valid", 32'(rsp_valid), 32'd1);
    check_val("single_rsp_id", 32'(rsp_id), 32'd2);
    check_val("single_rsp_data", rsp_data, 32'h00008000);
    rsp_ready = 1'b1;
    tick();
    check_val("single_rsp_done", 32'(rsp_valid), 32'd0);
    check_val("single_busy_done", 32'(busy), 32'd0);

    // Backpressure: the response is held for 10 cycles while requester 3 waits.
    rsp_ready = 1'b0;
    eng_sine = 32'hFFFF8000;
    ang[1] = 32'h12345678;
    ang[3] = 32'h0000ABCD;
    req_valid = 4'b0010;
    #1;
    check_val("bp_grant1", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b1000;
    wait_rsp("bp", n);
    for (int i = 0; i < 10; i++) begin
      check_val("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check_val("bp_rsp_id", 32'(rsp_id), 32'd1);
      check_val("bp_rsp_data", rsp_data, 32'hFFFF8000);
      check_val("bp_no_ready", 32'(req_ready), 32'd0);
      check_val("bp_no_start", 32'(eng_start), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check_val("bp_hs_no_grant", 32'(req_ready), 32'd0);
    tick();
    check_val("bp_rsp_dropped", 32'(rsp_valid), 32'd0);
    check_val("bp_next_grant", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;
    check_val("bp_next_angle", eng_angle, 32'h0000ABCD);
    wait_rsp("bp2", n);
    check_val("bp2_rsp_id", 32'(rsp_id), 32'd3);
    tick();

    // Abort: reset during WAIT, then both the late engine pulse and a stray pulse.
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    check_val("abort_start", 32'(eng_start), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    check_val("abort_busy_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      stray_valid = (i == 25);
      tick();
      if (rsp_valid || busy || eng_start) bad++;
    end
    stray_valid = 1'b0;
    check_val("abort_no_rsp", 32'(bad), 32'd0);

    // Timeout: the engine never answers.
    eng_mute = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    check_val("to_start", 32'(eng_start), 32'd1);
    n = 0;
    while (!rsp_valid && n < 150) begin
      tick();
      n++;
    end
`ifdef CORDIC_ARB_TIMEOUT_EN
    check_val("to_latency", 32'(n), 32'(TIMEOUT + 1));
    check_val("to_rsp_err", 32'(rsp_err), 32'd1);
    check_val("to_rsp_data", rsp_data, 32'd0);
    check_val("to_rsp_id", 32'(rsp_id), 32'd2);
    rsp_ready = 1'b1;
    tick();
    check_val("to_err_cleared", 32'(rsp_err), 32'd0);
    check_val("to_idle", 32'(busy), 32'd0);
`else
    check_val("to_never_valid", 32'(rsp_valid), 32'd0);
    check_val("to_still_busy", 32'(busy), 32'd1);
    check_val("to_err_tied", 32'(rsp_err), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("to_reset_idle", 32'(busy), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
